// File: rtl/blink_pkg.sv
// Shared definitions for the LED blink pattern driver: state encoding and default prescale.
package blink_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ON   = 2'd1;
  localparam logic [1:0] OFF  = 2'd2;

  localparam int TICK_DIV_DEF = 10;

  typedef enum logic [1:0] {
    S_IDLE = IDLE,
    S_ON   = ON,
    S_OFF  = OFF
  } state_t;

endpackage

// File: rtl/blink_tick_gen.sv
// Tick prescaler: one-cycle strobe every TICK_DIV clocks, restartable at 0 via clr.
module blink_tick_gen #(
  parameter int TICK_DIV = 10
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam logic [W-1:0] LAST = W'(TICK_DIV - 1);

  logic [W-1:0] cnt_q;

  assign tick = !clr && (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           cnt_q <= '0;
    else if (clr || tick) cnt_q <= '0;
    else                  cnt_q <= cnt_q + 1'b1;
  end

endmodule

// File: rtl/led_pattern_driver.sv
// LED on/off pattern generator: timed ON/OFF phases in prescaled ticks, finite or endless repeats.
module led_pattern_driver
  import blink_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_DEF,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [CNT_W-1:0] cmd_on,
  input  logic [CNT_W-1:0] cmd_off,
  input  logic [7:0]       cmd_reps,
  input  logic             abort,
  output logic             led,
  output logic             busy,
  output logic             done
);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] on_q, off_q, ph_q, ph_d;
  logic [7:0]       rep_q, rep_d;
  logic             tick, accept, done_d;

  // Phase counter reload value: a zero duration still lasts one tick.
  function automatic logic [CNT_W-1:0] ld(input logic [CNT_W-1:0] d);
    return (d == '0) ? '0 : d - 1'b1;
  endfunction

  assign cmd_ready = (state_q == S_IDLE);
  assign accept    = cmd_valid && cmd_ready;

  blink_tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (state_q == S_IDLE),
    .tick (tick)
  );

  always_comb begin
    state_d = state_q;
    ph_d    = ph_q;
    rep_d   = rep_q;
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: if (accept) begin
        state_d = S_ON;
        ph_d    = ld(cmd_on);
        rep_d   = cmd_reps;
      end
      S_ON: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
          rep_d   = '0;
        end else if (tick) begin
          if (ph_q == '0) begin
            state_d = S_OFF;
            ph_d    = ld(off_q);
          end else ph_d = ph_q - 1'b1;
        end
      end
      S_OFF: begin
        if (abort) begin
          state_d = S_IDLE;
          ph_d    = '0;
          rep_d   = '0;
        end else if (tick) begin
          if (ph_q != '0) ph_d = ph_q - 1'b1;
          else if (rep_q == 8'd1) begin
            state_d = S_IDLE;
            rep_d   = '0;
            done_d  = 1'b1;
          end else begin
            // rep_q == 0 is the endless mode and is never decremented
            state_d = S_ON;
            ph_d    = ld(on_q);
            if (rep_q != '0) rep_d = rep_q - 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ph_q    <= '0;
      rep_q   <= '0;
      on_q    <= '0;
      off_q   <= '0;
      led     <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state_q <= state_d;
      ph_q    <= ph_d;
      rep_q   <= rep_d;
      if (accept) begin
        on_q  <= cmd_on;
        off_q <= cmd_off;
      end
      led  <= (state_d == S_ON);
      busy <= (state_d != S_IDLE);
      done <= done_d;
    end
  end

endmodule

// File: tb/tb_led_pattern_driver.sv
// Randomized bench for led_pattern_driver against a per-cycle waveform model of the pattern.
module tb_led_pattern_driver;

  localparam int TD = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [CW-1:0] cmd_on = '0, cmd_off = '0;
  logic [7:0]    cmd_reps = '0;
  logic          abort = 1'b0;
  logic          led, busy, done;

  int checks = 0;
  int errors = 0;

  led_pattern_driver #(.TICK_DIV(TD), .CNT_W(CW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .cmd_valid(cmd_valid),
    .cmd_ready(cmd_ready),
    .cmd_on   (cmd_on),
    .cmd_off  (cmd_off),
    .cmd_reps (cmd_reps),
    .abort    (abort),
    .led      (led),
    .busy     (busy),
    .done     (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Sends a command at a negedge and follows it cycle by cycle. The model: with
  // T_on=max(on,1)*TD and T_off=max(off,1)*TD, cycle i after acceptance has
  // led=(i mod (T_on+T_off)) < T_on, busy=1; cycle reps*period is the done cycle.
  // abort_at>=0 raises abort during that cycle; noise throws junk commands while busy.
  task automatic run_cmd(input int on, input int off, input int reps,
                         input int abort_at, input bit noise);
    int ton, toff, per, total;
    bit finished;
    ton   = (on  == 0 ? 1 : on)  * TD;
    toff  = (off == 0 ? 1 : off) * TD;
    per   = ton + toff;
    total = (reps == 0) ? 4000 : reps * per;
    finished = 1'b0;
    chk("ready_before_cmd", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_on    = CW'(on);
    cmd_off   = CW'(off);
    cmd_reps  = 8'(reps);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int i = 0; i < 4100; i++) begin
      if (abort_at >= 0 && i == abort_at + 1) begin
        abort = 1'b0;
        chk("abort_led",   led, 0);
        chk("abort_busy",  busy, 0);
        chk("abort_done",  done, 0);
        chk("abort_ready", cmd_ready, 1);
        finished = 1'b1;
        break;
      end
      if (i == total) begin
        cmd_valid = 1'b0;
        chk("end_done", done, 1);
        chk("end_busy", busy, 0);
        chk("end_led",  led, 0);
        finished = 1'b1;
        break;
      end
      chk("led",   led, ((i % per) < ton) ? 1 : 0);
      chk("busy",  busy, 1);
      chk("done",  done, 0);
      chk("ready", cmd_ready, 0);
      abort = (i == abort_at);
      if (noise && $urandom_range(0, 5) == 0) begin
        cmd_valid = 1'b1;
        cmd_on    = CW'($urandom_range(0, 9));
        cmd_off   = CW'($urandom_range(0, 9));
        cmd_reps  = 8'($urandom_range(0, 5));
      end else cmd_valid = 1'b0;
      @(negedge clk);
    end
    if (!finished) chk("pattern_timeout", 0, 1);
    cmd_valid = 1'b0;
    abort = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_led",  led, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    chk("rst_ready", cmd_ready, 1);

    // Finite pattern, accepted on the first edge after reset release
    run_cmd(2, 3, 2, -1, 1'b0);
    @(negedge clk);
    chk("done_single", done, 0);

    // Endless pattern aborted at cycle 50 (abort ignored in IDLE beforehand)
    abort = 1'b1;
    run_cmd(1, 1, 0, 50, 1'b0);
    @(negedge clk);
    chk("post_abort_done", done, 0);

    // Zero durations: one tick each
    run_cmd(0, 0, 1, -1, 1'b0);

    // Command pulsed during ON must not disturb the pattern; back-to-back after done
    run_cmd(3, 1, 2, -1, 1'b1);
    run_cmd(1, 2, 1, -1, 1'b1);
    @(negedge clk);

    // Randomized patterns, some endless and aborted
    for (int n = 0; n < 12; n++) begin
      int on, off, reps, ab;
      on   = $urandom_range(0, 3);
      off  = $urandom_range(0, 3);
      reps = $urandom_range(0, 3);
      ab   = (reps == 0 || $urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_cmd(on, off, reps, ab, $urandom_range(0, 1) == 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Asynchronous reset in the middle of OFF
    chk("ready_before_rst", cmd_ready, 1);
    cmd_valid = 1'b1;
    cmd_on = CW'(1); cmd_off = CW'(3); cmd_reps = 8'd2;
    @(negedge clk);
    cmd_valid = 1'b0;
    repeat (6) @(negedge clk);
    chk("pre_rst_led",  led, 0);
    chk("pre_rst_busy", busy, 1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_led",  led, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_done", done, 0);
    end
    rst_n = 1'b1;
    run_cmd(1, 1, 1, -1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not reach the end, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
